itf_burst_master: RTL and testbench

Upstream bus-master stage for the `itf` byte interface. It accepts a byte stream on a valid/ready port and buffers it in a small FIFO. It then drives fixed-length write bursts, with auto-incrementing address and data, onto the `itf` Master-side signals (`addr`, `data`, `data_delayed`). The `test`-style consumer samples those signals.

---
 rtl/itf_pkg.sv | 13 +
 rtl/itf_sync_fifo.sv | 51 +++++
 rtl/itf_burst_master.sv | 107 ++++++++++
 tb/tb_itf_burst_master.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/itf_pkg.sv
// Shared types and default widths for the itf burst master slice.
package itf_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    GAP   = 2'd2
  } itf_burst_state_e;

  localparam int ITF_ADDR_W = 8;
  localparam int ITF_DATA_W = 8;

endpackage

// File: rtl/itf_sync_fifo.sv
// Synchronous FIFO holding all buffered bytes; head is the oldest entry.
module itf_sync_fifo
  import itf_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = ITF_DATA_W,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Storage is cleared so the head reads zero out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/itf_burst_master.sv
// Buffers an upstream byte stream and emits fixed-length itf write bursts.
// Optional data_delayed register: define ITF_BURST_MASTER_DATA_DELAYED_EN.
module itf_burst_master
  import itf_pkg::*;
#(
  parameter int ADDR_W    = ITF_ADDR_W,
  parameter int DATA_W    = ITF_DATA_W,
  parameter int DEPTH     = 4,
  parameter int BURST_LEN = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              flush,
  input  logic              bus_ready,
  output logic              bus_valid,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] data_delayed,
  output logic              burst_done
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  itf_burst_state_e  state, state_nxt;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  beats, beats_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic              push, pop;

  // in_ready depends only on the registered count, never on bus_ready.
  assign in_ready = (count != CNT_W'(DEPTH));
  assign push     = in_valid && in_ready;
  assign pop      = bus_valid && bus_ready;

  itf_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (in_data),
    .head  (data),
    .count (count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      addr  <= '0;
      beats <= '0;
    end else begin
      state <= state_nxt;
      addr  <= addr_nxt;
      beats <= beats_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    addr_nxt   = addr;
    beats_nxt  = beats;
    bus_valid  = 1'b0;
    burst_done = 1'b0;
    case (state)
      IDLE: begin
        if (count >= CNT_W'(BURST_LEN) || (flush && count != '0)) begin
          state_nxt = BURST;
          addr_nxt  = base_addr;
          beats_nxt = '0;
        end
      end
      BURST: begin
        bus_valid = (count != '0);
        if (bus_valid && bus_ready) begin
          addr_nxt  = addr + ADDR_W'(1);
          beats_nxt = beats + CNT_W'(1);
          // A flush burst ends when its last buffered byte leaves with no refill.
          if ((beats + CNT_W'(1)) == CNT_W'(BURST_LEN) ||
              (flush && count == CNT_W'(1) && !push)) begin
            state_nxt = GAP;
          end
        end
      end
      GAP: begin
        burst_done = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef ITF_BURST_MASTER_DATA_DELAYED_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     data_delayed <= '0;
    else if (pop) data_delayed <= data;
  end
`else
  assign data_delayed = '0;
`endif

endmodule

// File: tb/tb_itf_burst_master.sv
// Directed bench for itf_burst_master with a queue-based reference model.
module tb_itf_burst_master;

  localparam int DEPTH = 4;
  localparam int BL    = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] base_addr;
  logic       flush;
  logic       bus_ready;
  logic       bus_valid;
  logic [7:0] addr;
  logic [7:0] data;
  logic [7:0] data_delayed;
  logic       burst_done;

  int errors = 0;
  int checks = 0;

  itf_burst_master #(
    .ADDR_W    (8),
    .DATA_W    (8),
    .DEPTH     (DEPTH),
    .BURST_LEN (BL)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .base_addr    (base_addr),
    .flush        (flush),
    .bus_ready    (bus_ready),
    .bus_valid    (bus_valid),
    .addr         (addr),
    .data         (data),
    .data_delayed (data_delayed),
    .burst_done   (burst_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: FIFO contents as a queue plus burst bookkeeping.
  logic [7:0] q[$];
  bit         m_active, m_gap;
  logic [7:0] m_addr, m_dd;
  int         m_beats, sz;
  bit         pop_e, push_e;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q.delete();
      m_active = 0; m_gap = 0; m_addr = 8'h00; m_beats = 0; m_dd = 8'h00;
    end else begin
      sz     = q.size();
      pop_e  = m_active && sz != 0 && bus_ready;
      push_e = in_valid && sz != DEPTH;
      if (m_gap) begin
        m_gap = 0;
      end else if (!m_active) begin
        if (sz >= BL || (flush && sz != 0)) begin
          m_active = 1; m_addr = base_addr; m_beats = 0;
        end
      end else if (pop_e) begin
        m_addr  = m_addr + 8'h01;
        m_beats = m_beats + 1;
        if (m_beats == BL || (flush && sz == 1 && !push_e)) begin
          m_active = 0; m_gap = 1;
        end
`ifdef ITF_BURST_MASTER_DATA_DELAYED_EN
        m_dd = q[0];
`endif
      end
      if (pop_e)  void'(q.pop_front());
      if (push_e) q.push_back(in_data);
    end
  end

  // Per-cycle comparison against the model, plus a log of accepted beats.
  logic [7:0] log_a[$];
  logic [7:0] log_d[$];

  always @(negedge clk) begin
    chk("in_ready", in_ready, q.size() != DEPTH);
    chk("bus_valid", bus_valid, m_active && q.size() != 0);
    chk("burst_done", burst_done, m_gap);
    chk("addr", addr, m_addr);
    if (m_active && q.size() != 0) chk("data", data, q[0]);
    chk("data_delayed", data_delayed, m_dd);
    if (bus_valid && bus_ready) begin
      log_a.push_back(addr);
      log_d.push_back(data);
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    in_valid = 1'b1; in_data = b;
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    bit seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (burst_done) begin seen = 1; break; end
    end
    chk(nm, seen, 1);
    cyc();
  endtask

  task automatic chk_log(input string nm, input logic [7:0] a0, input logic [7:0] d0,
                         input logic [7:0] dstep);
    logic [7:0] ea, ed;
    chk({nm, "_len"}, log_a.size(), BL);
    ea = a0; ed = d0;
    for (int i = 0; i < BL && i < log_a.size(); i++) begin
      chk({nm, "_addr"}, log_a[i], ea);
      chk({nm, "_data"}, log_d[i], ed);
      ea = ea + 8'h01; ed = ed + dstep;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; in_data = 8'h00; in_valid = 1'b0; base_addr = 8'h00;
    flush = 1'b0; bus_ready = 1'b0;
    repeat (3) cyc();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_bus_valid", bus_valid, 0);
    chk("rst_addr", addr, 8'h00);
    chk("rst_data", data, 8'h00);
    chk("rst_data_delayed", data_delayed, 8'h00);
    chk("rst_burst_done", burst_done, 0);
    rst = 1'b1;
    cyc();

    // Basic burst and latency
    base_addr = 8'h10; bus_ready = 1'b1;
    log_a.delete(); log_d.delete();
    push_byte(8'h11); push_byte(8'h22); push_byte(8'h33); push_byte(8'h44);
    @(negedge clk); chk("lat_first", bus_valid, 0);
    @(negedge clk); chk("lat_second", bus_valid, 1);
    wait_done("s1_done");
    chk_log("s1", 8'h10, 8'h11, 8'h11);
`ifdef ITF_BURST_MASTER_DATA_DELAYED_EN
    chk("s1_dd", data_delayed, 8'h44);
    chk("s1_model_dd", m_dd, 8'h44);
`else
    chk("s1_dd", data_delayed, 8'h00);
`endif
    chk("s1_model_addr", m_addr, 8'h14);

    // Address wrap
    base_addr = 8'hFE;
    log_a.delete(); log_d.delete();
    push_byte(8'h01); push_byte(8'h02); push_byte(8'h03); push_byte(8'h04);
    wait_done("s2_done");
    chk_log("s2", 8'hFE, 8'h01, 8'h01);

    // Backpressure with full FIFO
    base_addr = 8'h20; bus_ready = 1'b0;
    push_byte(8'hA1); push_byte(8'hA2); push_byte(8'hA3); push_byte(8'hA4);
    chk("s3_full_ready", in_ready, 0);
    repeat (3) cyc();
    chk("s3_hold_valid", bus_valid, 1);
    chk("s3_hold_addr", addr, 8'h20);
    chk("s3_hold_data", data, 8'hA1);
    bus_ready = 1'b1; cyc(); bus_ready = 1'b0;
    chk("s3_ready_back", in_ready, 1);
    chk("s3_next_addr", addr, 8'h21);
    chk("s3_next_data", data, 8'hA2);
    repeat (2) cyc();
    bus_ready = 1'b1;
    wait_done("s3_done");

    // Partial FIFO needs flush
    base_addr = 8'h30;
    log_a.delete(); log_d.delete();
    push_byte(8'h5A); push_byte(8'h5B);
    repeat (6) cyc();
    chk("s4_no_burst", log_a.size(), 0);
    chk("s4_no_valid", bus_valid, 0);
    flush = 1'b1;
    wait_done("s4_done");
    flush = 1'b0;
    chk("s4_len", log_a.size(), 2);
    if (log_a.size() == 2) begin
      chk("s4_addr0", log_a[0], 8'h30);
      chk("s4_data1", log_d[1], 8'h5B);
    end

    // Reset mid-burst
    base_addr = 8'h40;
    log_a.delete(); log_d.delete();
    push_byte(8'h71); push_byte(8'h72); push_byte(8'h73); push_byte(8'h74);
    begin
      bit got2 = 0;
      repeat (20) begin
        cyc();
        if (log_a.size() >= 2) begin got2 = 1; break; end
      end
      chk("s5_two_beats", got2, 1);
    end
    rst = 1'b0;
    #1;
    chk("s5_rst_valid", bus_valid, 0);
    chk("s5_rst_addr", addr, 8'h00);
    chk("s5_rst_done", burst_done, 0);
    chk("s5_rst_ready", in_ready, 1);
    chk("s5_rst_dd", data_delayed, 8'h00);
    repeat (2) cyc();
    rst = 1'b1;
    cyc();
    base_addr = 8'h50;
    log_a.delete(); log_d.delete();
    push_byte(8'h81); push_byte(8'h82); push_byte(8'h83); push_byte(8'h84);
    wait_done("s5_done");
    chk_log("s5", 8'h50, 8'h81, 8'h01);

    repeat (3) cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
